muldiv_seq: RTL and testbench

Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS core. It accepts one R-type mult/multu/div/divu/mthi/mtlo request from the execute stage and runs a 32-iteration shift-add multiply or restoring divide. It commits the result to the architectural HI/LO registers and holds `busy` so the pipeline stalls any dependent mfhi/mflo or new muldiv issue. The main ALU is untouched; this block owns HI/LO exclusively.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_muldiv_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer, its decoder and the hazard unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  muldiv_pkg::step_mode_t mode,
  input  logic [XLEN-1:0]        acc,
  input  logic [XLEN-1:0]        op_reg,
  input  logic [XLEN-1:0]        operand,
  output logic [XLEN-1:0]        acc_next,
  output logic [XLEN-1:0]        op_next
);
  import muldiv_pkg::*;

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (op_reg[0] ? {1'b0, operand} : '0);
    shifted  = {acc, op_reg[XLEN-1]};
    diff     = shifted - {1'b0, operand};
    // multiply: {carry, acc, multiplier} shifts right one place
    acc_next = sum[XLEN:1];
    op_next  = {sum[0], op_reg[XLEN-1:1]};
    if (mode == MODE_DIV) begin
      // remainder < divisor keeps shifted below 2*divisor, so diff[XLEN] is the borrow
      if (!diff[XLEN]) begin
        acc_next = diff[XLEN-1:0];
        op_next  = {op_reg[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        op_next  = {op_reg[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: 32-iteration shift-add multiply / restoring divide,
// single-cycle mthi/mtlo and divide-by-zero, owns the architectural HI/LO registers.
module muldiv_seq #(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import muldiv_pkg::*;

  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, opr, operand;
  logic [XLEN-1:0] acc_next, opr_next;
  logic            neg_lo, neg_hi, is_div;

  logic            is_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            accept;

  always_comb begin
    is_signed = (funct == FN_MULT) || (funct == FN_DIV);
    sa        = is_signed & a[XLEN-1];
    sb        = is_signed & b[XLEN-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    accept    = start && !flush;
    prod_fix  = neg_lo ? -{acc, opr} : {acc, opr};
    q_fix     = neg_lo ? -opr : opr;
    r_fix     = neg_hi ? -acc : acc;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (state == S_DIV ? MODE_DIV : MODE_MUL),
    .acc      (acc),
    .op_reg   (opr),
    .operand  (operand),
    .acc_next (acc_next),
    .op_next  (opr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (funct == FN_MULT || funct == FN_MULTU)                 state_next = S_MUL;
          else if ((funct == FN_DIV || funct == FN_DIVU) && b != '0) state_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)                 state_next = S_IDLE;
        else if (cnt == CNT_LAST)  state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opr     <= '0;
      operand <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      is_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (funct)
              FN_MULT, FN_MULTU: begin
                acc     <= '0;
                opr     <= mag_b;
                operand <= mag_a;
                neg_lo  <= sa ^ sb;
                neg_hi  <= sa ^ sb;
                is_div  <= 1'b0;
                cnt     <= '0;
              end
              FN_DIV, FN_DIVU: begin
                if (b == '0) begin
                  hi   <= a;
                  lo   <= '1;
                  done <= 1'b1;
                end else begin
                  acc     <= '0;
                  opr     <= mag_a;
                  operand <= mag_b;
                  neg_lo  <= sa ^ sb;
                  neg_hi  <= sa;
                  is_div  <= 1'b1;
                  cnt     <= '0;
                end
              end
              FN_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              FN_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_next;
          opr <= opr_next;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed table-driven bench for muldiv_seq plus hand-written flush/reset/back-to-back sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after the start-sampling edge; counts edges until done is seen.
  task automatic wait_done(output int lat, output int bn);
    lat = 0;
    bn  = 0;
    while (!done && lat < TMO) begin
      if (busy) bn++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int bn);
    @(negedge clk);
    funct = f;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bn);
  endtask

  initial begin
    int lat, bn, lat2, bn2;
    string nm;

    vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
    vecs[1]  = '{FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33};
    vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
    vecs[3]  = '{FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 33};
    vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33};
    vecs[5]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33};
    vecs[6]  = '{FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33};
    vecs[7]  = '{FN_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0,  0};
    vecs[8]  = '{FN_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 0,  0};
    vecs[9]  = '{FN_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0,  0};
    vecs[10] = '{FN_MFHI,  32'd99,       32'd0,        32'h00001234, 32'h00005678, TMO, 0};
    vecs[11] = '{FN_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 0,  0};
    vecs[12] = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 33};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, lat, bn);
      nm = $sformatf("v%0d", i);
      check({nm, "_lat"},  64'(lat), 64'(vecs[i].exp_lat));
      check({nm, "_busy"}, 64'(bn),  64'(vecs[i].exp_busy));
      check({nm, "_hi"},   64'(hi),  64'(vecs[i].exp_hi));
      check({nm, "_lo"},   64'(lo),  64'(vecs[i].exp_lo));
      @(posedge clk);
      #1;
      check({nm, "_pulse"}, 64'(done), 64'd0);
    end

    // flush at iteration 10 of a mult: HI/LO stay 0/1
    @(negedge clk);
    funct = FN_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    wait_done(lat, bn);
    check("flush_no_done", 64'(lat), 64'(TMO));
    check("flush_hi", 64'(hi), 64'd0);
    check("flush_lo", 64'(lo), 64'd1);

    // start held high with a different request while busy
    @(negedge clk);
    funct = FN_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    funct = FN_MTLO; a = 32'hDEAD;
    repeat (20) @(posedge clk);
    #1;
    check("held_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(lat2, bn2);
    check("held_lat", 64'(lat2), 64'd13);
    check("held_hi", 64'(hi), 64'd0);
    check("held_lo", 64'(lo), 64'd42);

    // back-to-back: mthi issued in the cycle done is high
    funct = FN_MTHI; a = 32'hBEEF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_hi", 64'(hi), 64'hBEEF);
    check("b2b_lo", 64'(lo), 64'd42);

    // flush in IDLE drops a simultaneous start
    @(negedge clk);
    funct = FN_MTHI; a = 32'h777; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_done", 64'(done), 64'd0);
    check("idle_flush_hi", 64'(hi), 64'hBEEF);

    // asynchronous reset at iteration 20
    @(negedge clk);
    funct = FN_MULT; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(FN_DIVU, 32'd100, 32'd7, lat, bn);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_hi", 64'(hi), 64'd2);
    check("post_rst_lo", 64'(lo), 64'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
